// File: rtl/cross_bar_bank_arbiter_if.sv
// Request/grant bundle between the channel buffers, one bank arbiter and its cache bank.
// The arbiter connects through the slave modport. The channel/bank side connects through the master modport.
interface cross_bar_bank_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]    ch_req_valid_i;
    logic [NUM_CH*28-1:0] ch_req_addr_i;
    logic [NUM_CH-1:0]    ch_grant_o;
    logic                 bank_req_valid_o;
    logic                 bank_req_ready_i;
    logic [27:0]          bank_req_addr_o;
    logic [CH_W-1:0]      bank_req_chid_o;
    logic                 arb_full_o;

    modport slave (
        input  ch_req_valid_i,
        input  ch_req_addr_i,
        input  bank_req_ready_i,
        output ch_grant_o,
        output bank_req_valid_o,
        output bank_req_addr_o,
        output bank_req_chid_o,
        output arb_full_o
    );

    modport master (
        output ch_req_valid_i,
        output ch_req_addr_i,
        output bank_req_ready_i,
        input  ch_grant_o,
        input  bank_req_valid_o,
        input  bank_req_addr_o,
        input  bank_req_chid_o,
        input  arb_full_o
    );
endinterface

// File: rtl/cross_bar_bank_arbiter.sv
// Per-bank round-robin arbiter over the channel request buffers.
// A 2-entry FIFO toward the bank keeps the grant path independent of bank ready.
module cross_bar_bank_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int BANK_ID = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    cross_bar_bank_arbiter_if.slave     bus
);

    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0]      count_q, count_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;

    logic [27:0]     fifo_addr_q [2];
    logic [CH_W-1:0] fifo_chid_q [2];

    logic [27:0]     ch_addr [NUM_CH];
    logic [CH_W-1:0] win;
    logic            any_valid;
    logic            full;
    logic            push;
    logic            pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_addr[gi]        = bus.ch_req_addr_i[28*gi +: 28];
            assign bus.ch_grant_o[gi] = push && (win == CH_W'(gi));
        end
    endgenerate

    // Rotating priority: the first requester at or above rr_ptr wins.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        any_valid = 1'b0;
        win       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = CH_W'(idx);
            if (!any_valid && bus.ch_req_valid_i[cand]) begin
                any_valid = 1'b1;
                win       = cand;
            end
        end
    end

    // A full FIFO blocks the grant even when the bank pops this cycle.
    assign full = (count_q == 2'd2);
    assign push = any_valid && !full && rst_ni;
    assign pop  = (count_q != 2'd0) && bus.bank_req_ready_i;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; it is only observed while count is nonzero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= ch_addr[win];
            fifo_chid_q[wr_ptr_q] <= win;
        end
    end

    // Misroute guard: address bits [9:8] (field bits [5:4]) must name this bank.
    always_ff @(posedge clk_i) begin
        if (push) begin
            assert (ch_addr[win][5:4] == 2'(BANK_ID));
        end
    end

    assign bus.bank_req_valid_o = (count_q != 2'd0);
    assign bus.bank_req_addr_o  = fifo_addr_q[rd_ptr_q];
    assign bus.bank_req_chid_o  = fifo_chid_q[rd_ptr_q];
    assign bus.arb_full_o       = full;

endmodule

// File: tb/tb_cross_bar_bank_arbiter.sv
// Directed, table-driven bench for the bank arbiter.
// Each row is one clock cycle of inputs plus the outputs expected in that cycle.
module tb_cross_bar_bank_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    cross_bar_bank_arbiter_if #(.NUM_CH(4), .CH_W(2)) bus ();

    cross_bar_bank_arbiter #(.NUM_CH(4), .CH_W(2), .BANK_ID(0)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] grant;
        logic       bvalid;
        logic [1:0] chid;
        logic       full;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    // Every channel presents a distinct head address whose bits [5:4] are zero (bank 0).
    function automatic logic [27:0] exp_addr(input int k);
        return 28'h0ABC000 + 28'(k) * 28'h101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic rdy,
                       input logic [3:0] g, input logic bv, input logic [1:0] c, input logic f);
        vec_t e;
        e.rst_n = r; e.valid = v; e.ready = rdy;
        e.grant = g; e.bvalid = bv; e.chid = c; e.full = f;
        tbl.push_back(e);
    endtask

    // Drive at the falling edge, compare 1 ns later, well before the next rising edge.
    task automatic drive(input logic r, input logic [3:0] v, input logic rdy);
        @(negedge clk);
        rst_n                = r;
        bus.ch_req_valid_i   = v;
        bus.bank_req_ready_i = rdy;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic bv,
                             input logic [1:0] c, input logic f);
        chk({tag, " grant"}, 32'(bus.ch_grant_o), 32'(g));
        chk({tag, " valid"}, 32'(bus.bank_req_valid_o), 32'(bv));
        chk({tag, " full"},  32'(bus.arb_full_o), 32'(f));
        if (bv) begin
            chk({tag, " chid"}, 32'(bus.bank_req_chid_o), 32'(c));
            chk({tag, " addr"}, 32'(bus.bank_req_addr_o), 32'(exp_addr(int'(c))));
        end
        $display("%s rst_n=%b valid=%b ready=%b grant=%b bank_valid=%b chid=%0d full=%b",
                 tag, rst_n, bus.ch_req_valid_i, bus.bank_req_ready_i, bus.ch_grant_o,
                 bus.bank_req_valid_o, bus.bank_req_chid_o, bus.arb_full_o);
    endtask

    initial begin
        //    rst  valid    rdy  grant    bv  chid  full
        // reset held two cycles with every channel requesting
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        // all valid, ready: grants rotate 0,1,2,3,0; bank sees chid one cycle later
        add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0);
        add(1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b0);
        add(1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b0);
        add(1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b0);
        add(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b0);
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
        // only ch2 requests; rr_ptr becomes 3
        add(1'b1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0);
        // wrap: ch0 and ch3 request, ch3 first, then ch0
        add(1'b1, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b0);
        add(1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b0);
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
        // ready while empty is ignored; ch3 grant brings rr_ptr back to 0
        add(1'b1, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0);
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0);
        // ch0,ch1 with ready low: fill to 2, full blocks grants even with ready high
        add(1'b1, 4'b0011, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0);
        add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0);
        add(1'b1, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1);
        add(1'b1, 4'b0011, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1);
        // after the pop a grant resumes (rr_ptr=2 -> ch0); head is now chid1
        add(1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd1, 1'b0);
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1);
        add(1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
        add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        rst_n                = 1'b0;
        bus.ch_req_valid_i   = 4'b1111;
        bus.bank_req_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.ch_req_addr_i[28*k +: 28] = exp_addr(k);
        end
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].valid, tbl[i].ready);
            check_out($sformatf("row%0d", i), tbl[i].grant, tbl[i].bvalid, tbl[i].chid, tbl[i].full);
        end

        // Reset mid-operation with the FIFO full (rr_ptr is 1 here).
        drive(1'b1, 4'b0010, 1'b0);
        check_out("rst_fill0", 4'b0010, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 4'b0100, 1'b0);
        check_out("rst_fill1", 4'b0100, 1'b1, 2'd1, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);
        check_out("rst_full", 4'b0000, 1'b1, 2'd1, 1'b1);
        // grant is masked during the reset cycle; state still shows the old contents
        drive(1'b0, 4'b1111, 1'b1);
        check_out("rst_mask", 4'b0000, 1'b1, 2'd1, 1'b1);
        // pointer restarted at 0: ch1 beats ch3
        drive(1'b1, 4'b1010, 1'b0);
        check_out("rst_rel", 4'b0010, 1'b0, 2'd0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0);
        check_out("rst_head", 4'b0000, 1'b1, 2'd1, 1'b0);
        // head payload must hold while ready stays low
        drive(1'b1, 4'b0000, 1'b0);
        check_out("rst_hold", 4'b0000, 1'b1, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
